// File: rtl/stopwatch_cmd_arbiter_if.sv
// Command/status bundle between two stopwatch command requesters, the arbiter and the stopwatch core.
// The slave side is the arbiter; the master side is the requesters plus the core.
interface stopwatch_cmd_arbiter_if;
   logic       req0_valid;
   logic [1:0] req0_cmd;
   logic       req0_ready;
   logic       req1_valid;
   logic [1:0] req1_cmd;
   logic       req1_ready;
   logic [1:0] sw_status;
   logic       sw_start;
   logic       sw_stop;
   logic       sw_reset;
   logic       tick;
   logic       grant_id;
   logic       cmd_err;

   modport slave (
      input  req0_valid, req0_cmd, req1_valid, req1_cmd, sw_status,
      output req0_ready, req1_ready, sw_start, sw_stop, sw_reset, tick, grant_id, cmd_err
   );

   modport master (
      output req0_valid, req0_cmd, req1_valid, req1_cmd, sw_status,
      input  req0_ready, req1_ready, sw_start, sw_stop, sw_reset, tick, grant_id, cmd_err
   );
endinterface

// File: rtl/stopwatch_cmd_arbiter.sv
// Round-robin arbiter between a button path and a host path that issues filtered start/stop/clear
// pulses to a stopwatch core and paces it with a prescaled tick while it is running.
module stopwatch_cmd_arbiter #(
   parameter int unsigned CLK_DIV = 100,
   parameter int unsigned HOLDOFF = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   stopwatch_cmd_arbiter_if.slave bus
);

   localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   localparam logic [1:0] CMD_START = 2'b00;
   localparam logic [1:0] CMD_STOP  = 2'b01;
   localparam logic [1:0] CMD_CLEAR = 2'b10;
   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_RUN    = 2'b01;
   localparam logic [1:0] ST_PAUSED = 2'b10;

   typedef enum logic [1:0] {ARB, ISSUE, HOLD} state_t;

   state_t          state_q, state_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            prio1_q, prio1_d;
   logic            grant_q, grant_d;
   logic            start_q, start_d;
   logic            stop_q, stop_d;
   logic            clear_q, clear_d;
   logic            err_q, err_d;
   logic            tick_q, tick_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic            ready0_c, ready1_c;
   logic [1:0]      sel_cmd;

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB;
         hold_q  <= '0;
         prio1_q <= 1'b0;
         grant_q <= 1'b0;
         start_q <= 1'b0;
         stop_q  <= 1'b0;
         clear_q <= 1'b0;
         err_q   <= 1'b0;
         tick_q  <= 1'b0;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         prio1_q <= prio1_d;
         grant_q <= grant_d;
         start_q <= start_d;
         stop_q  <= stop_d;
         clear_q <= clear_d;
         err_q   <= err_d;
         tick_q  <= tick_d;
         presc_q <= presc_d;
      end
   end

   // Arbitration, command filtering and issue/holdoff sequencing
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      prio1_d  = prio1_q;
      grant_d  = grant_q;
      start_d  = 1'b0;
      stop_d   = 1'b0;
      clear_d  = 1'b0;
      err_d    = 1'b0;
      ready0_c = 1'b0;
      ready1_c = 1'b0;
      sel_cmd  = CMD_START;

      case (state_q)
         ARB: begin
            // Ready is withheld while rst is asserted so nothing is accepted during reset
            ready0_c = !rst && bus.req0_valid && (!bus.req1_valid || !prio1_q);
            ready1_c = !rst && bus.req1_valid && (!bus.req0_valid ||  prio1_q);
            if (ready0_c || ready1_c) begin
               state_d = ISSUE;
               grant_d = ready1_c;
               prio1_d = ready0_c;
               sel_cmd = ready1_c ? bus.req1_cmd : bus.req0_cmd;
               case (sel_cmd)
                  CMD_START: start_d = (bus.sw_status == ST_IDLE) || (bus.sw_status == ST_PAUSED);
                  CMD_STOP:  stop_d  = (bus.sw_status == ST_RUN);
                  CMD_CLEAR: clear_d = 1'b1;
                  default:   err_d   = 1'b1;
               endcase
            end
         end
         ISSUE: begin
            if (HOLDOFF == 0) begin
               state_d = ARB;
            end else begin
               state_d = HOLD;
               hold_d  = '0;
            end
         end
         HOLD: begin
            if (hold_q == HW'(HOLDOFF - 1)) begin
               state_d = ARB;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = ARB;
      endcase
   end

   // Tick prescaler: advances only while the core runs, cleared around a clear pulse
   always_comb begin
      presc_d = presc_q;
      tick_d  = 1'b0;
      if (clear_d || clear_q) begin
         presc_d = '0;
      end else if (bus.sw_status == ST_RUN) begin
         presc_d = (presc_q == PW'(CLK_DIV - 1)) ? '0 : presc_q + 1'b1;
         tick_d  = (presc_d == PW'(CLK_DIV - 1));
      end
   end

   assign bus.req0_ready = ready0_c;
   assign bus.req1_ready = ready1_c;
   assign bus.sw_start   = start_q;
   assign bus.sw_stop    = stop_q;
   assign bus.sw_reset   = clear_q;
   assign bus.tick       = tick_q;
   assign bus.grant_id   = grant_q;
   assign bus.cmd_err    = err_q;

endmodule

// File: tb/tb_stopwatch_cmd_arbiter.sv
// Self-checking bench for stopwatch_cmd_arbiter: vector table through a pulse scoreboard,
// plus hand-written holdoff, prescaler and mid-operation reset sequences.
module tb_stopwatch_cmd_arbiter;
   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned HOLDOFF = 2;

   localparam logic [1:0] S = 2'b00, P = 2'b01, C = 2'b10, R = 2'b11;
   localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, PAU = 2'b10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stopwatch_cmd_arbiter_if bus();

   stopwatch_cmd_arbiter #(.CLK_DIV(CLK_DIV), .HOLDOFF(HOLDOFF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       v0;
      logic [1:0] c0;
      logic       v1;
      logic [1:0] c1;
      logic [1:0] st;
      logic       r0;
      logic       r1;
      logic       gid;
      logic [3:0] pul;   // {start, stop, reset, err}
   } vec_t;

   typedef struct {
      logic [3:0] pul;
      logic       gid;
   } exp_t;

   vec_t vec [10];
   exp_t sb [$];
   int   passed = 0;
   int   total  = 0;

   function automatic vec_t mk(input logic v0, input logic [1:0] c0, input logic v1,
                               input logic [1:0] c1, input logic [1:0] st, input logic r0,
                               input logic r1, input logic gid, input logic [3:0] pul);
      vec_t v;
      v.v0 = v0; v.c0 = c0; v.v1 = v1; v.c1 = c1; v.st = st;
      v.r0 = r0; v.r1 = r1; v.gid = gid; v.pul = pul;
      return v;
   endfunction

   function automatic logic [3:0] pulses();
      return {bus.sw_start, bus.sw_stop, bus.sw_reset, bus.cmd_err};
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic push(input logic [3:0] pul, input logic gid);
      exp_t e;
      e.pul = pul;
      e.gid = gid;
      sb.push_back(e);
   endtask

   // Called one cycle after a handshake, when the registered pulses are visible
   task automatic pop_check(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         $display("FAIL %s: scoreboard empty, got pulses %0h", name, pulses());
      end else begin
         e = sb.pop_front();
         chk({name, "_pulses"}, 8'(pulses()), 8'(e.pul));
         chk({name, "_grant"}, 8'(bus.grant_id), 8'(e.gid));
      end
   endtask

   task automatic drive(input logic v0, input logic [1:0] c0, input logic v1,
                        input logic [1:0] c1, input logic [1:0] st);
      bus.req0_valid = v0; bus.req0_cmd = c0;
      bus.req1_valid = v1; bus.req1_cmd = c1;
      bus.sw_status  = st;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      drive(1'b0, S, 1'b0, S, IDLE);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec[0] = mk(1, S, 0, S, IDLE, 1, 0, 0, 4'b1000);
      vec[1] = mk(1, S, 1, P, IDLE, 0, 1, 1, 4'b0000);
      vec[2] = mk(1, P, 1, S, RUN,  1, 0, 0, 4'b0100);
      vec[3] = mk(0, S, 1, C, RUN,  0, 1, 1, 4'b0010);
      vec[4] = mk(1, R, 0, S, IDLE, 1, 0, 0, 4'b0001);
      vec[5] = mk(1, S, 0, S, PAU,  1, 0, 0, 4'b1000);
      vec[6] = mk(1, C, 1, R, PAU,  0, 1, 1, 4'b0001);
      vec[7] = mk(0, S, 1, S, RUN,  0, 1, 1, 4'b0000);
      vec[8] = mk(1, P, 0, S, PAU,  1, 0, 0, 4'b0000);
      vec[9] = mk(1, S, 1, C, IDLE, 0, 1, 1, 4'b0010);

      rst = 1'b1;
      drive(1'b1, S, 1'b1, S, IDLE);
      @(posedge clk); #4;
      chk("reset_outputs", {bus.req0_ready, bus.req1_ready, pulses(), bus.tick, bus.grant_id}, 8'h00);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, S, 1'b0, S, IDLE);

      // Vector table: handshake at N, pulses at N+1, quiet at N+2, next vector at N+4
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         drive(vec[i].v0, vec[i].c0, vec[i].v1, vec[i].c1, vec[i].st);
         #3;
         chk($sformatf("v%0d_ready", i), 8'({bus.req0_ready, bus.req1_ready}), 8'({vec[i].r0, vec[i].r1}));
         push(vec[i].pul, vec[i].gid);
         @(posedge clk); #1;
         bus.req0_valid = 1'b0;
         bus.req1_valid = 1'b0;
         #3;
         pop_check($sformatf("v%0d", i));
         @(posedge clk); #4;
         chk($sformatf("v%0d_single_pulse", i), 8'(pulses()), 8'h00);
         @(posedge clk);
      end

      // Both valid, req0 wins; req1 held and served once holdoff expires
      do_reset();
      @(posedge clk); #1;
      drive(1'b1, S, 1'b1, P, IDLE);
      #3;
      chk("rr_n_ready", 8'({bus.req0_ready, bus.req1_ready}), 8'b10);
      push(4'b1000, 1'b0);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.sw_status  = RUN;
      #3;
      pop_check("rr_n1");
      chk("rr_n1_ready1", 8'(bus.req1_ready), 8'h0);
      for (int k = 2; k <= 3; k++) begin
         @(posedge clk); #4;
         chk($sformatf("rr_n%0d_hold_ready1", k), 8'(bus.req1_ready), 8'h0);
      end
      @(posedge clk); #4;
      chk("rr_n4_ready1", 8'(bus.req1_ready), 8'h1);
      push(4'b0100, 1'b1);
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      #3;
      pop_check("rr_n5");

      // Prescaler: 10 running, 3 paused, then running again
      do_reset();
      for (int k = 0; k < 17; k++) begin
         @(posedge clk); #1;
         bus.sw_status = (k < 10 || k >= 13) ? RUN : PAU;
         #3;
         chk($sformatf("tick_c%0d", k), 8'(bus.tick), 8'((k == 3) || (k == 7) || (k == 14)));
      end

      // Reset during HOLD with prescaler at 2, then req1 alone on the first clock
      do_reset();
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         bus.sw_status = RUN;
      end
      @(posedge clk); #1;
      drive(1'b1, S, 1'b0, S, PAU);
      #3;
      chk("rst_seq_ready0", 8'(bus.req0_ready), 8'h1);
      push(4'b1000, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, S, 1'b1, S, PAU);
      #3;
      pop_check("rst_seq_issue");
      @(posedge clk); #1;
      rst = 1'b1;
      #3;
      chk("rst_mid_outputs", {bus.req0_ready, bus.req1_ready, pulses(), bus.tick, bus.grant_id}, 8'h00);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.sw_status = RUN;
      #3;
      chk("rst_release_ready1", 8'({bus.req0_ready, bus.req1_ready}), 8'b01);
      chk("rst_tick_r0", 8'(bus.tick), 8'h0);
      push(4'b0000, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         bus.req1_valid = 1'b0;
         #3;
         if (k == 1) pop_check("rst_release");
         chk($sformatf("rst_tick_r%0d", k), 8'(bus.tick), 8'(k == 3));
      end

      if (sb.size() != 0) begin
         total++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
